uart_tx_arbiter: RTL

//  Shares one UART transmitter between NUM_REQ byte-stream requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Function : Round-robin share of one UART TX byte stream among NUM_REQ
//            requesters; grant held per frame or per MAX_BURST bytes.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_VALID,
    input  logic                          TX_READY,
    output logic [NUM_REQ-1:0]            GRANT,
    output logic                          BUSY
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_BURST_END = c_CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
    localparam logic [c_IDX_W-1:0] c_PTR_RST   = c_IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_gidx;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                  w_found;
    logic [c_IDX_W-1:0]    w_sel;
    logic [DATA_WIDTH-1:0] w_tx_data;
    logic                  w_tx_valid;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_burst_hit;

    // First valid requester searching upward from r_ptr+1 with wrap.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int               idx;
            logic [c_IDX_W-1:0] cand;
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = c_IDX_W'(idx);
            if (!w_found && REQ_VALID[cand]) begin
                w_found = 1'b1;
                w_sel   = cand;
            end
        end
    end

    // r_grant is one-hot in OWN and zero in IDLE, so it doubles as the mux select.
    always_comb begin
        w_tx_data  = '0;
        w_tx_valid = 1'b0;
        w_last     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_tx_data  = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                w_tx_valid = REQ_VALID[i];
                w_last     = REQ_LAST[i];
            end
        end
    end

    assign w_xfer      = w_tx_valid & TX_READY;
    assign w_burst_hit = (MAX_BURST != 0) && (r_count == c_BURST_END);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= c_PTR_RST;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_OWN;
                        r_grant <= NUM_REQ'(1) << w_sel;
                        r_gidx  <= w_sel;
                        r_count <= '0;
                    end
                end
                S_OWN: begin
                    if (w_xfer) begin
                        if (w_last || w_burst_hit) begin
                            r_state <= S_IDLE;
                            r_grant <= '0;
                            r_ptr   <= r_gidx;
                            r_count <= '0;
                        end else if (MAX_BURST != 0) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign GRANT     = r_grant;
    assign BUSY      = (r_state == S_OWN);
    assign TX_DATA   = w_tx_data;
    assign TX_VALID  = w_tx_valid;
    assign REQ_READY = r_grant & {NUM_REQ{TX_READY}};

endmodule
`default_nettype wire
